// File: rtl/alu_pkg.sv
// Shared definitions for the shift-unit issue logic: funct codes, FSM states, op record.
// Optional tag field controlled by ALU_SHIFT_ISSUE_TAG_EN.
package alu_pkg;

  localparam logic [2:0] FN_SHL    = 3'b000;
  localparam logic [2:0] FN_SHR    = 3'b001;
  localparam logic [2:0] FN_ASHR   = 3'b010;
  localparam logic [2:0] FN_FSHIFT = 3'b011;

  localparam int unsigned TAG_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_WAITF = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [2:0]       funct;
`ifdef ALU_SHIFT_ISSUE_TAG_EN
    logic [TAG_W-1:0] tag;
`endif
  } op_t;

endpackage

// File: rtl/alu_op_fifo.sv
// Op request FIFO: DEPTH entries (power of two), pointers wrap naturally modulo DEPTH.
module alu_op_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 67
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is pure datapath; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/alu_shift_issue.sv
// Issues queued shift ops to an external shift unit one at a time and holds each result until taken.
// Optional op tag passthrough enabled by ALU_SHIFT_ISSUE_TAG_EN.
module alu_shift_issue
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [2:0]       in_funct,
`ifdef ALU_SHIFT_ISSUE_TAG_EN
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] res_tag,
`endif
  output logic             iss_valid,
  output logic [31:0]      iss_a,
  output logic [31:0]      iss_b,
  output logic [2:0]       iss_funct,
  input  logic             unit_valid,
  input  logic [31:0]      unit_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data
);

  op_t         push_op, head_op;
  logic        fifo_full, fifo_empty, pop;
  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] res_data_q, res_data_d;
  logic        capture_ext;
`ifdef ALU_SHIFT_ISSUE_TAG_EN
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
`endif

  always_comb begin
    push_op       = '0;
    push_op.a     = in_a;
    push_op.b     = in_b;
    push_op.funct = in_funct;
`ifdef ALU_SHIFT_ISSUE_TAG_EN
    push_op.tag   = in_tag;
`endif
  end

  alu_op_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(op_t))
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (in_valid && in_ready),
    .push_data (push_op),
    .pop       (pop),
    .head      (head_op),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Issue is the IDLE cycle that pops the head, so the unit sees the op in the same cycle.
  assign in_ready  = !fifo_full;
  assign pop       = (state_q == ST_IDLE) && !fifo_empty;
  assign iss_valid = pop;
  assign iss_a     = pop ? head_op.a     : '0;
  assign iss_b     = pop ? head_op.b     : '0;
  assign iss_funct = pop ? head_op.funct : '0;

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
`ifdef ALU_SHIFT_ISSUE_TAG_EN
  assign res_tag   = res_tag_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    capture_ext = 1'b0;
`ifdef ALU_SHIFT_ISSUE_TAG_EN
    res_tag_d   = res_tag_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
`ifdef ALU_SHIFT_ISSUE_TAG_EN
          res_tag_d = head_op.tag;
`endif
          if (head_op.funct == FN_FSHIFT) begin
            if (head_op.b[4:0] == 5'd0) begin
              state_d     = ST_HOLD;
              res_valid_d = 1'b1;
              res_data_d  = head_op.a;
            end else begin
              state_d = ST_WAITF;
              cnt_d   = head_op.b[4:0];
            end
          end else begin
            state_d = ST_WAIT1;
          end
        end
      end
      ST_WAIT1: begin
        capture_ext = 1'b1;
        res_data_d  = unit_result;
        res_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_WAITF: begin
        // Count of 1 marks the n-th cycle after issue; the unit result is taken then.
        if (cnt_q == 5'd1) begin
          capture_ext = 1'b1;
          res_data_d  = unit_result;
          res_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
`ifdef ALU_SHIFT_ISSUE_TAG_EN
      res_tag_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
`ifdef ALU_SHIFT_ISSUE_TAG_EN
      res_tag_q   <= res_tag_d;
`endif
    end
  end

  unit_valid_at_capture: assert property (
    @(posedge clk) disable iff (!reset_n) capture_ext |-> unit_valid
  );

endmodule

// File: tb/tb_alu_shift_issue.sv
// Self-checking bench for alu_shift_issue with a behavioural shift unit and a timestamp-based reference model.
`timescale 1ns/1ps
module tb_alu_shift_issue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic [2:0]  in_funct = '0;
  logic [3:0]  in_tag = '0;
  logic        iss_valid;
  logic [31:0] iss_a, iss_b;
  logic [2:0]  iss_funct;
  logic        unit_valid;
  logic [31:0] unit_result;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
`ifdef ALU_SHIFT_ISSUE_TAG_EN
  logic [3:0]  res_tag;
`endif

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;

  always #5 clk = ~clk;

  alu_shift_issue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_funct    (in_funct),
`ifdef ALU_SHIFT_ISSUE_TAG_EN
    .in_tag      (in_tag),
    .res_tag     (res_tag),
`endif
    .iss_valid   (iss_valid),
    .iss_a       (iss_a),
    .iss_b       (iss_b),
    .iss_funct   (iss_funct),
    .unit_valid  (unit_valid),
    .unit_result (unit_result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic [3:0]  tag;
  } tb_op_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // What the shift unit computes; FSHIFT by 0 returns junk that the issuer must ignore.
  function automatic logic [31:0] unit_value(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] f);
    int unsigned n = b[4:0];
    if (f[2]) return a;
    case (f)
      3'd0:    return a << n;
      3'd1:    return a >> n;
      3'd2:    return 32'($signed(a) >>> n);
      default: return (n == 0) ? ~a : ((a << n) | (a >> (32 - n)));
    endcase
  endfunction

  function automatic int unit_lat(input logic [31:0] b, input logic [2:0] f);
    return (f == 3'd3 && b[4:0] != 5'd0) ? int'(b[4:0]) : 1;
  endfunction

  function automatic logic [31:0] exp_result(input tb_op_t o);
    return (o.f == 3'd3 && o.b[4:0] == 5'd0) ? o.a : unit_value(o.a, o.b, o.f);
  endfunction

  // Cycles from the issue cycle to the first cycle res_valid is seen.
  function automatic int exp_lat(input tb_op_t o);
    if (o.f != 3'd3) return 2;
    return (o.b[4:0] == 5'd0) ? 1 : int'(o.b[4:0]) + 1;
  endfunction

  // Behavioural shift unit: result and sticky valid appear after its latency.
  logic [31:0] u_a, u_b;
  logic [2:0]  u_f;
  int          u_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      unit_valid  <= 1'b0;
      unit_result <= '0;
      u_cnt       <= 0;
    end else if (iss_valid) begin
      u_a <= iss_a; u_b <= iss_b; u_f <= iss_funct;
      if (unit_lat(iss_b, iss_funct) == 1) begin
        unit_valid  <= 1'b1;
        unit_result <= unit_value(iss_a, iss_b, iss_funct);
        u_cnt       <= 0;
      end else begin
        unit_valid  <= 1'b0;
        unit_result <= $urandom;
        u_cnt       <= unit_lat(iss_b, iss_funct) - 1;
      end
    end else if (u_cnt > 0) begin
      u_cnt <= u_cnt - 1;
      if (u_cnt == 1) begin
        unit_valid  <= 1'b1;
        unit_result <= unit_value(u_a, u_b, u_f);
      end else begin
        unit_result <= $urandom;
      end
    end
  end

  // Reference model: queue of accepted ops plus the in-flight op and its completion time.
  tb_op_t q[$];
  tb_op_t fl;
  bit     m_busy = 1'b0;
  int     done_at = 0;
  int     cyc = 0;
  logic   e_ready, e_iss, e_res;

  initial begin : model
    forever begin
      @(negedge clk);
      e_ready = (q.size() < DEPTH);
      e_iss   = !m_busy && (q.size() != 0);
      e_res   = m_busy && (cyc >= done_at);
      if (reset_n) begin
        check("in_ready", in_ready, e_ready);
        check("iss_valid", iss_valid, e_iss);
        if (e_iss) begin
          check("iss_a", iss_a, q[0].a);
          check("iss_b", iss_b, q[0].b);
          check("iss_funct", iss_funct, q[0].f);
        end
        check("res_valid", res_valid, e_res);
        if (e_res) begin
          check("res_data", res_data, exp_result(fl));
`ifdef ALU_SHIFT_ISSUE_TAG_EN
          check("res_tag", res_tag, fl.tag);
`endif
        end
      end
      @(posedge clk);
      if (!reset_n) begin
        q.delete();
        m_busy = 1'b0;
      end else begin
        if (e_res && res_ready) m_busy = 1'b0;
        if (e_iss) begin
          fl      = q.pop_front();
          m_busy  = 1'b1;
          done_at = cyc + exp_lat(fl);
        end
        if (in_valid && e_ready) q.push_back('{a: in_a, b: in_b, f: in_funct, tag: in_tag});
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input int lat, input logic [31:0] data);
    int t_iss = -1;
    int t_res = -1;
    logic [31:0] got = '0;
    in_valid = 1'b1; in_a = a; in_b = b; in_funct = f;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 60 && t_res < 0; k++) begin
      @(negedge clk);
      if (iss_valid && t_iss < 0) t_iss = k;
      if (res_valid && t_res < 0) begin t_res = k; got = res_data; end
    end
    check({name, "_done"}, 32'(t_iss >= 0 && t_res >= 0), 32'd1);
    check({name, "_lat"}, 32'(t_res - t_iss), 32'(lat));
    check({name, "_data"}, got, data);
    tick();
  endtask

  task automatic push_n(input int n, input logic [2:0] f0, input logic [31:0] b0,
                        input logic [31:0] base, output int acc);
    logic r;
    acc = 0;
    for (int k = 0; k < 40 && acc < n; k++) begin
      in_valid = 1'b1;
      in_a     = base + 32'(acc);
      in_b     = (acc == 0) ? b0 : $urandom;
      in_funct = (acc == 0) ? f0 : 3'(4 + $urandom_range(0, 3));
      in_tag   = 4'(acc + 1);
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      if (r) acc++;
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int acc;
    logic [31:0] got[$];
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_iss_valid", iss_valid, 0);
    check("rst_iss_a", iss_a, 0);
    check("rst_iss_b", iss_b, 0);
    check("rst_iss_funct", iss_funct, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
`ifdef ALU_SHIFT_ISSUE_TAG_EN
    check("rst_res_tag", res_tag, 0);
`endif
    reset_n = 1'b1;
    repeat (2) tick();

    run_one("shl", 32'h1, 32'd4, 3'd0, 2, 32'h10);
    run_one("fshift3", 32'hDEAD_BEEF, 32'd3, 3'd3, 4, 32'hF56D_F77E);
    run_one("fshift0", 32'h1234_5678, 32'h20, 3'd3, 1, 32'h1234_5678);
    run_one("ashr", 32'h8000_0000, 32'd4, 3'd2, 2, 32'hF800_0000);
    run_one("shr", 32'h8000_0000, 32'd4, 3'd1, 2, 32'h0800_0000);

    // Fill: one op in flight plus DEPTH queued with the result held.
    res_ready = 1'b0;
    push_n(5, 3'd4, 32'd0, 32'h100, acc);
    check("fill_accepted", 32'(acc), 32'd5);
    @(negedge clk);
    check("fill_in_ready", in_ready, 0);
    tick();
    res_ready = 1'b1;
    got.delete();
    for (int k = 0; k < 100 && got.size() < 5; k++) begin
      @(negedge clk);
      if (res_valid) got.push_back(res_data);
      tick();
    end
    check("fill_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5 && i < got.size(); i++) check("fill_order", got[i], 32'h100 + 32'(i));

    // Reset while waiting on a long FSHIFT with three ops behind it.
    res_ready = 1'b0;
    push_n(4, 3'd3, 32'd10, 32'h200, acc);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_res_valid", res_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_iss_valid", iss_valid, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    res_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("postrst_res_valid", res_valid, 0);
      check("postrst_iss_valid", iss_valid, 0);
    end
    tick();
    run_one("postrst_shl", 32'h3, 32'd2, 3'd0, 2, 32'hC);

`ifdef ALU_SHIFT_ISSUE_TAG_EN
    begin : tag_seq
      logic [3:0] tags[$];
      logic [2:0] fs[3] = '{3'd1, 3'd2, 3'd3};
      logic r;
      int n = 0;
      res_ready = 1'b0;
      for (int k = 0; k < 20 && n < 3; k++) begin
        in_valid = 1'b1; in_a = $urandom; in_b = 32'd2; in_funct = fs[n]; in_tag = 4'(n + 1);
        @(negedge clk);
        r = in_ready;
        @(posedge clk);
        if (r) n++;
        #1;
      end
      in_valid = 1'b0;
      res_ready = 1'b1;
      for (int k = 0; k < 60 && tags.size() < 3; k++) begin
        @(negedge clk);
        if (res_valid) tags.push_back(res_tag);
        tick();
      end
      check("tag_count", 32'(tags.size()), 32'd3);
      for (int i = 0; i < 3 && i < tags.size(); i++) check("tag_seq", 32'(tags[i]), 32'(i + 1));
    end
`endif

    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_a      = $urandom;
      in_b      = $urandom;
      in_funct  = 3'($urandom_range(0, 7));
      if (in_funct == 3'd3) in_b[4:0] = 5'($urandom_range(0, 6));
      in_tag    = 4'($urandom);
      res_ready = ($urandom_range(0, 99) < 70);
      tick();
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 300 && (m_busy || q.size() != 0); k++) tick();
    check("drain_idle", 32'(m_busy || q.size() != 0), 32'd0);

    repeat (2) tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_shift_issue.md
ALU_SHIFT_ISSUE -- requirements
Module: alu_shift_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of input FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1: op request handshake.
REQ-005 SHALL have ports in_a input 32, in_b input 32, in_funct input 3: op operands and code.
REQ-006 SHALL have ports iss_valid output 1, iss_a output 32, iss_b output 32, iss_funct output 3, driving the shift unit's valid_i/a/b/funct.
REQ-007 SHALL have ports unit_valid input 1, unit_result input 32, from the shift unit's valid_o/result.
REQ-008 SHALL have ports res_valid output 1, res_ready input 1, res_data output 32: result handshake.

Function
REQ-009 SHALL accept an op on the clk edge where in_valid and in_ready are both 1; in_ready = FIFO not full.
REQ-010 SHALL run FSM IDLE, WAIT1, WAITF, HOLD; reset state IDLE.
REQ-011 IDLE with FIFO non-empty SHALL pop the head and assert iss_valid for exactly one cycle with its a/b/funct; iss_valid SHALL be 0 in all other states.
REQ-012 Funct 000 SHL, 001 SHR, 010 ASHR, 1xx pass-through SHALL go IDLE->WAIT1; WAIT1 SHALL capture unit_result into res_data and go HOLD.
REQ-013 Funct 011 FSHIFT with n = b[4:0] > 0 SHALL go IDLE->WAITF, load a 5-bit countdown with n, decrement each cycle, and capture unit_result n+1 cycles after the issue cycle, then go HOLD.
REQ-014 FSHIFT with n = 0 SHALL still issue but complete locally: res_data = a, next state HOLD one cycle after issue, unit_result ignored.
REQ-015 Completion SHALL be timed by the FSM only; unit_valid is level-sticky and SHALL NOT be used as a completion strobe (only checked under REQ-019).
REQ-016 HOLD SHALL assert res_valid with stable res_data until res_ready=1, then go IDLE; a new op SHALL issue no earlier than the cycle after the handshake.
REQ-017 Exactly one op SHALL be in flight; simultaneous FIFO push and pop SHALL keep occupancy unchanged, including when full (push is blocked by in_ready=0).
REQ-018 FIFO pointers SHALL wrap modulo DEPTH; ordering SHALL be strict FIFO.
REQ-019 Capture cycle with unit_valid=0 (non-local completion) SHALL be a protocol error flagged by assertion only; RTL behaviour is capture regardless.

Reset
REQ-020 reset_n low SHALL asynchronously clear FIFO to empty, FSM to IDLE, countdown to 0, and set iss_valid=0, iss_a/iss_b=0, iss_funct=0, res_valid=0, res_data=0; in_ready SHALL read 1 after reset.
REQ-021 Reset mid-operation SHALL discard the in-flight op and all queued ops with no res_valid pulse; the shift unit SHALL be reset from the same source (inverted at top level).

Configuration
REQ-022 With ALU_SHIFT_ISSUE_TAG_EN defined, ports in_tag input 4 and res_tag output 4 SHALL exist, the tag SHALL travel with its op through FIFO and HOLD, and res_tag SHALL reset to 0.
REQ-023 Without ALU_SHIFT_ISSUE_TAG_EN, the tag ports and storage SHALL be absent and all other behaviour identical.

Structure
REQ-024 Funct codes SHL/SHR/ASHR/FSHIFT, FSM state encoding and the tag width SHALL live in shared package alu_pkg.
REQ-025 The FIFO SHALL be a sub-module alu_op_fifo (parameter DEPTH, width 67 or 71 with tag); FSM and countdown stay in alu_shift_issue.

Verification
REQ-026 SHL a=0x0000_0001 b=4 -> iss_valid 1 cycle, res_valid 2 cycles after issue, res_data=0x0000_0010.
REQ-027 FSHIFT a=0xDEAD_BEEF b=3 -> no res_valid before issue+4, capture at issue+4, res_data=unit value; next op not issued until after handshake.
REQ-028 FSHIFT a=0x1234_5678 b=0x20 (n=0) -> res_data=0x1234_5678 one cycle after issue, no hang.
REQ-029 Push 5 ops with DEPTH=4 and res_ready=0 -> in_ready=0 after 4 accepted plus 1 in flight; release res_ready -> all results in order, pointer wrap exercised.
REQ-030 Assert reset_n low during WAITF with 3 ops queued -> res_valid stays 0, in_ready=1, FIFO empty, FSM IDLE after release.
REQ-031 With ALU_SHIFT_ISSUE_TAG_EN, tags 0x1,0x2,0x3 on SHR/ASHR/FSHIFT -> res_tag sequence 0x1,0x2,0x3.
